// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and compares them with expected values.
// Optional build macro SYSID_READER_AUTOSTART_EN launches one check automatically after reset release.
module sysid_reader #(
    parameter logic [31:0] EXP_ID      = 32'd151178878,
    parameter logic [31:0] EXP_TS      = 32'd1526974626,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_ID,
        RD_TS,
        FIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          go;
    logic          ack;
    logic          expired;

`ifdef SYSID_READER_AUTOSTART_EN
    // One-shot request armed by reset, consumed on the first edge spent in IDLE.
    logic auto_pending;

    always_ff @(posedge clk) begin
        if (!reset_n)
            auto_pending <= 1'b1;
        else if (state == IDLE)
            auto_pending <= 1'b0;
    end

    assign go = start || auto_pending;
`else
    assign go = start;
`endif

    assign ack     = !avm_waitrequest;
    assign expired = avm_waitrequest && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (go)
                    state_next = RD_ID;
            end
            RD_ID: begin
                avm_read = 1'b1;
                busy     = 1'b1;
                if (ack)
                    state_next = RD_TS;
                else if (expired)
                    state_next = FIN;
            end
            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                busy        = 1'b1;
                if (ack || expired)
                    state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // match is settled on the timestamp capture edge so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            match    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        wait_cnt <= '0;
                        id_ok    <= 1'b0;
                        ts_ok    <= 1'b0;
                        match    <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (ack) begin
                        wait_cnt <= '0;
                        if (state == RD_ID) begin
                            id_value <= avm_readdata;
                            id_ok    <= (avm_readdata == EXP_ID);
                        end else begin
                            ts_value <= avm_readdata;
                            ts_ok    <= (avm_readdata == EXP_TS);
                            match    <= id_ok && (avm_readdata == EXP_TS);
                        end
                    end else if (expired) begin
                        wait_cnt <= '0;
                        timeout  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_reader.sv
// Self-checking bench for sysid_reader: table-driven checks against a waitrequest-programmable responder.
// Expected results are queued at each accepted start and compared when done pulses.
module tb_sysid_reader;

    localparam int          TO      = 8;
    localparam logic [31:0] GOOD_ID = 32'd151178878;
    localparam logic [31:0] GOOD_TS = 32'd1526974626;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        match;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    always #5 clk = ~clk;

    sysid_reader #(
        .EXP_ID(GOOD_ID),
        .EXP_TS(GOOD_TS),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy(busy),
        .done(done),
        .id_ok(id_ok),
        .ts_ok(ts_ok),
        .match(match),
        .timeout(timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    typedef struct {
        logic [31:0] id_data;
        logic [31:0] ts_data;
        int          wait_id;
        int          wait_ts;
        logic        hold;
        logic        id_ok;
        logic        ts_ok;
        logic        match;
        logic        timeout;
        int          lat;
    } vec_t;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        match;
        logic        timeout;
        logic [31:0] id_value;
        logic [31:0] ts_value;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          read_seen = 0;
    int          stab_err = 0;
    logic [31:0] rsp_id = GOOD_ID;
    logic [31:0] rsp_ts = GOOD_TS;
    int          rsp_wait_id = 0;
    int          rsp_wait_ts = 0;
    int          rsp_cnt = 0;
    logic        addr_log[$];
    logic [31:0] last_id = '0;
    logic [31:0] last_ts = '0;
    logic        pend = 1'b0;
    logic        paddr = 1'b0;
    vec_t        vecs[11];

    // Responder stalls each access for a programmed number of cycles, then returns its data word.
    assign avm_waitrequest = avm_read && (rsp_cnt < (avm_address ? rsp_wait_ts : rsp_wait_id));
    assign avm_readdata    = avm_address ? rsp_ts : rsp_id;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_read && avm_waitrequest)
            rsp_cnt <= rsp_cnt + 1;
        else
            rsp_cnt <= 0;
        if (avm_read && !avm_waitrequest && reset_n)
            addr_log.push_back(avm_address);
        if (pend && !timeout && !(avm_read && avm_address == paddr))
            stab_err <= stab_err + 1;
        pend  <= avm_read && avm_waitrequest && reset_n;
        paddr <= avm_address;
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (avm_read)
            read_seen++;
        if (reset_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.lat != 0)
                    checkOutput("latency", cyc - mon_e.start_cyc + 1, mon_e.lat);
                checkOutput("id_ok", id_ok, mon_e.id_ok);
                checkOutput("ts_ok", ts_ok, mon_e.ts_ok);
                checkOutput("match", match, mon_e.match);
                checkOutput("timeout", timeout, mon_e.timeout);
                checkOutput("id_value", id_value, mon_e.id_value);
                checkOutput("ts_value", ts_value, mon_e.ts_value);
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   n;
        int   base;
        int   exp_xfers;
        rsp_id      = v.id_data;
        rsp_ts      = v.ts_data;
        rsp_wait_id = v.wait_id;
        rsp_wait_ts = v.wait_ts;
        addr_log.delete();
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_xfers = 0;
        if (v.wait_id < TO) begin
            last_id = v.id_data;
            exp_xfers = 1;
            if (v.wait_ts < TO) begin
                last_ts = v.ts_data;
                exp_xfers = 2;
            end
        end
        e.id_ok     = v.id_ok;
        e.ts_ok     = v.ts_ok;
        e.match     = v.match;
        e.timeout   = v.timeout;
        e.id_value  = last_id;
        e.ts_value  = last_ts;
        e.lat       = v.lat;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        checkOutput("cleared_on_start", {id_ok, ts_ok, match, timeout}, 4'b0000);
        if (!v.hold)
            start = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done)
                break;
        end
        if (n == 100)
            checkOutput("done_wait_expired", 0, 1);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("done_count", done_cnt - base, 1);
        checkOutput("xfer_count", addr_log.size(), exp_xfers);
        for (int i = 0; i < addr_log.size(); i++)
            checkOutput("addr_seq", addr_log[i], i);
        checkOutput("addr_read_stable", stab_err, 0);
    endtask

    initial begin
        int n;
        //            id_data       ts_data       wid  wts  hold  idok tsok mtch tout lat
        vecs[0]  = '{GOOD_ID,      GOOD_TS,      0,   0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3};
        vecs[1]  = '{GOOD_ID + 1,  GOOD_TS,      0,   0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        vecs[2]  = '{GOOD_ID,      32'h0,        0,   0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        vecs[3]  = '{32'hFFFFFFFF, 32'h12345678, 0,   0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[4]  = '{GOOD_ID,      GOOD_TS,      4,   4,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11};
        vecs[5]  = '{GOOD_ID,      GOOD_TS,      7,   0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10};
        vecs[6]  = '{GOOD_ID,      GOOD_TS,      0,   7,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10};
        vecs[7]  = '{GOOD_ID,      GOOD_TS,      1000, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9};
        vecs[8]  = '{GOOD_ID,      GOOD_TS,      0,   1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10};
        vecs[9]  = '{GOOD_ID,      GOOD_TS,      0,   0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3};
        vecs[10] = '{GOOD_ID,      GOOD_TS,      8,   0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9};

        repeat (3) @(negedge clk);
        checkOutput("reset_read", avm_read, 0);
        checkOutput("reset_address", avm_address, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_flags", {id_ok, ts_ok, match, timeout}, 4'b0000);
        checkOutput("reset_values", {id_value, ts_value}, 64'h0);

`ifdef SYSID_READER_AUTOSTART_EN
        mon_e.id_ok     = 1'b1;
        mon_e.ts_ok     = 1'b1;
        mon_e.match     = 1'b1;
        mon_e.timeout   = 1'b0;
        mon_e.id_value  = GOOD_ID;
        mon_e.ts_value  = GOOD_TS;
        mon_e.lat       = 0;
        mon_e.start_cyc = 0;
        exp_q.push_back(mon_e);
        last_id = GOOD_ID;
        last_ts = GOOD_TS;
`endif
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
`ifdef SYSID_READER_AUTOSTART_EN
        checkOutput("autostart_done_count", done_cnt, 1);
`else
        checkOutput("no_read_without_start", read_seen, 0);
`endif

        for (int i = 0; i < 11; i++)
            applyStimulus(vecs[i]);

        // Reset pulled while the timestamp read is stalled must wipe everything on the next edge.
        rsp_id      = GOOD_ID;
        rsp_ts      = GOOD_TS;
        rsp_wait_id = 0;
        rsp_wait_ts = 3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (avm_read && avm_address)
                break;
        end
        checkOutput("reached_rd_ts", n < 20, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_read", avm_read, 0);
        checkOutput("midreset_busy_done", {busy, done}, 2'b00);
        checkOutput("midreset_flags", {id_ok, ts_ok, match, timeout}, 4'b0000);
        checkOutput("midreset_values", {id_value, ts_value}, 64'h0);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sysid_reader.md
# sysid_reader

Avalon-MM read master that queries the system-ID peripheral (32-bit ID word at address 0, 32-bit build timestamp at address 1) and checks both words against compile-time expected values. Sits next to the Nios/Qsys system on the same clock and drives the sysid control slave directly or through the interconnect. Its pass/fail result gates firmware-version-dependent logic and drives a status LED, so a mismatched FPGA image is caught in hardware.

## Interface
Parameters:
- EXP_ID, 32'd151178878, expected system ID word at address 0
- EXP_TS, 32'd1526974626, expected timestamp word at address 1
- TIMEOUT_CYC, 255, maximum consecutive waitrequest-high cycles per access before abort; legal range 1..65535

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous reset, active-low
- start  in  1  request a check; sampled only in IDLE
- avm_address  out  1  word address: 0 = ID, 1 = timestamp
- avm_read  out  1  read strobe
- avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest
- avm_waitrequest  in  1  slave stall
- busy  out  1  high in RD_ID and RD_TS
- done  out  1  one-cycle pulse when a check completes or aborts
- id_ok  out  1  captured ID == EXP_ID
- ts_ok  out  1  captured timestamp == EXP_TS
- match  out  1  id_ok && ts_ok && !timeout
- timeout  out  1  last check aborted on waitrequest timeout
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

## Operation
- FSM states: IDLE, RD_ID, RD_TS, FIN.
- IDLE: avm_read=0. start=1 → RD_ID; same edge clears id_ok, ts_ok, match, timeout and the wait counter.
- RD_ID: avm_read=1, avm_address=0. On edge with avm_waitrequest=0: id_value<=avm_readdata, id_ok<=(avm_readdata==EXP_ID), counter cleared, → RD_TS.
- RD_TS: avm_read=1, avm_address=1. On edge with avm_waitrequest=0: ts_value<=avm_readdata, ts_ok<=compare, → FIN.
- FIN: done=1, match=id_ok&&ts_ok, avm_read=0, → IDLE unconditionally.
- Wait counter: width clog2(TIMEOUT_CYC+1); increments each edge in RD_ID/RD_TS with avm_waitrequest=1. On edge where counter==TIMEOUT_CYC-1 and waitrequest still high: timeout<=1, → FIN (match forced 0; id_ok/ts_ok keep captured-so-far values, uncaptured ones remain 0).
- avm_address and avm_read held stable while avm_waitrequest=1 (Avalon rule).
- start while busy or in FIN: ignored, not queued.
- Result outputs (id_ok, ts_ok, match, timeout, id_value, ts_value) hold until next accepted start.

## Timing
- Reset values: state IDLE, avm_read=0, avm_address=0, busy=0, done=0, all flags 0, id_value=ts_value=0, counter 0.
- Zero wait states: start sampled at edge E0 → avm_read high cycles E0..E2 (addr 0 then 1) → done high for the cycle after edge E2 → result visible with done, 3 cycles after start.
- Each waitrequest cycle adds one cycle of latency.
- Timeout: abort after exactly TIMEOUT_CYC waitrequest-high edges in one access; done follows next cycle.
- Reset asserted mid-access: avm_read drops at the next edge; no partial results retained.
- Waitrequest deasserting on the same edge the counter expires: transfer completes, no timeout.

## Configuration
- SYSID_READER_AUTOSTART_EN: when defined, an internal one-shot launches a check on the first edge after reset_n deasserts (equivalent to start=1 in IDLE), then behaves normally. When undefined, checks run only on external start.

## Test plan
- Responder returns 151178878 / 1526974626, no waitrequest; start pulse → done 3 cycles later, id_ok=ts_ok=match=1, timeout=0, avm_address sequence 0,1.
- Responder returns ID 151178879 → id_ok=0, ts_ok=1, match=0, id_value=151178879.
- waitrequest held 4 cycles on each access, TIMEOUT_CYC=255 → address/read stable throughout, done at cycle 11, match=1.
- waitrequest stuck high, TIMEOUT_CYC=8 → avm_read drops after 8 wait edges, timeout=1, match=0, done single pulse; next start clears timeout.
- start asserted every cycle during a check → exactly one done per check; reset_n low mid-RD_TS → avm_read=0 and all outputs 0 next cycle.
- With SYSID_READER_AUTOSTART_EN defined and start tied 0 → one check runs after reset release, match=1; without macro → no avm_read ever asserted.
